// File: rtl/dmem_responder.sv
// Data-memory responder for the load/store path.
// Accepts one request at a time and serves it after a fixed latency. The
// request commits to the word array on the edge that raises rsp_valid, so a
// later request always sees this store's data.
module dmem_responder #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH_LOG2 = 10,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
   parameter int                    LATENCY    = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_wen,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_wmask,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err
);

   localparam int NUM_LANES = DATA_WIDTH / 8;
   localparam int OFF_BITS  = $clog2(NUM_LANES);
   localparam int CNT_WIDTH = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int NUM_WORDS = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_RESP
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
   logic                    wen_q, wen_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [NUM_LANES-1:0]    wmask_q, wmask_d;
   logic                    rsp_err_q, rsp_err_d;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q;

   logic                    accept;
   logic                    commit;
   logic                    clear_rsp;

   // Transaction being committed: with a single-cycle latency it commits on
   // the accepting edge straight from the request inputs.
   logic                    c_wen;
   logic [ADDR_WIDTH-1:0]   c_addr;
   logic [DATA_WIDTH-1:0]   c_wdata;
   logic [NUM_LANES-1:0]    c_wmask;
   logic [ADDR_WIDTH-1:0]   c_off;
   logic [ADDR_WIDTH-1:0]   c_word;
   logic [DEPTH_LOG2-1:0]   c_idx;
   logic                    c_in_range;

   logic [DATA_WIDTH-1:0]   mem [0:NUM_WORDS-1];

   assign req_ready = !rst && (state_q == ST_IDLE || (state_q == ST_RESP && rsp_ready));
   assign accept    = req_valid && req_ready;

   assign c_wen   = (LATENCY == 1) ? req_wen   : wen_q;
   assign c_addr  = (LATENCY == 1) ? req_addr  : addr_q;
   assign c_wdata = (LATENCY == 1) ? req_wdata : wdata_q;
   assign c_wmask = (LATENCY == 1) ? req_wmask : wmask_q;

   // Word index relative to the base; addresses below the base wrap to a huge
   // offset and are rejected by the unsigned compare.
   assign c_off      = c_addr - BASE_ADDR;
   assign c_word     = c_off >> OFF_BITS;
   assign c_idx      = c_word[DEPTH_LOG2-1:0];
   assign c_in_range = (c_addr >= BASE_ADDR) && (c_word[ADDR_WIDTH-1:DEPTH_LOG2] == '0);

   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

   // Next-state, latency countdown, request capture and commit strobes.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wen_d     = wen_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wmask_d   = wmask_q;
      commit    = 1'b0;
      clear_rsp = 1'b0;

      case (state_q)
         ST_IDLE: begin
         end
         ST_BUSY: begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
            if (cnt_q == CNT_WIDTH'(1)) begin
               state_d = ST_RESP;
               commit  = 1'b1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d   = ST_IDLE;
               clear_rsp = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A new request may be taken from IDLE or on the response handshake.
      if (accept) begin
         wen_d   = req_wen;
         addr_d  = req_addr;
         wdata_d = req_wdata;
         wmask_d = req_wmask;
         cnt_d   = CNT_WIDTH'(LATENCY - 1);
         if (LATENCY == 1) begin
            state_d = ST_RESP;
            commit  = 1'b1;
         end else begin
            state_d = ST_BUSY;
         end
      end

      rsp_err_d = rsp_err_q;
      if (commit) begin
         rsp_err_d = !c_in_range;
      end else if (clear_rsp) begin
         rsp_err_d = 1'b0;
      end
   end

   // Control state and error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rsp_err_q <= rsp_err_d;
      end
   end

   // Captured request fields; only meaningful while a transaction is open.
   always_ff @(posedge clk) begin
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
   end

   // Byte-lane store into the array; a reset on the commit edge cancels it.
   always_ff @(posedge clk) begin
      if (!rst && commit && c_wen && c_in_range) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (c_wmask[i]) begin
               mem[c_idx][i*8 +: 8] <= c_wdata[i*8 +: 8];
            end
         end
      end
   end

   // Registered read of the array into the response data register.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_rdata_q <= '0;
      end else if (commit) begin
         rsp_rdata_q <= (!c_wen && c_in_range) ? mem[c_idx] : '0;
      end else if (clear_rsp) begin
         rsp_rdata_q <= '0;
      end
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the NPC load/store path. It answers load/store requests issued by the memory-access side of the pipeline over a valid/ready request channel. Each request is served after a fixed, parameterised latency. It returns read data or a write acknowledgement over a valid/ready response channel. This block supplies the load data that the MEM stage later sign- or zero-extends.

Parameters:
ADDR_WIDTH, 32, byte-address width
DATA_WIDTH, 32, data word width; must be a power of two and at least 8
DEPTH_LOG2, 10, log2 of the number of words in the internal array
BASE_ADDR, 32'h8000_0000, byte address of word 0
LATENCY, 2, cycles from request acceptance to rsp_valid; must be at least 1

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_wen  in  1  1 = store, 0 = load
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data, already lane-aligned
req_wmask  in  DATA_WIDTH/8  byte-lane write enables
rsp_valid  out  1  response present
rsp_ready  in  1  initiator accepts the response
rsp_rdata  out  DATA_WIDTH  full read word; 0 for stores and for errors
rsp_err  out  1  address out of range

Behaviour:
- Reset: clk/rst synchronous, active-high. rst forces state IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0. req_ready=0 while rst is high. The memory array is not reset.
- States: IDLE, BUSY, RESP. One transaction is outstanding at most.
- req_ready = !rst && (state==IDLE || (state==RESP && rsp_ready)).
- Accept occurs when req_valid && req_ready at a clock edge:
  - latch wen, addr, wdata and wmask;
  - cnt <= LATENCY-1;
  - next state is RESP if LATENCY==1, else BUSY.
- BUSY: cnt <= cnt-1 each cycle; when cnt==1, next state is RESP. rsp_valid first becomes high exactly LATENCY cycles after the accepting edge.
- Commit happens on the edge that enters RESP:
  - index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8). The low address bits are ignored; lane selection is the initiator's job.
  - The address is in range iff addr >= BASE_ADDR and index < 2**DEPTH_LOG2.
  - Load in range: rsp_rdata <= mem[index], rsp_err <= 0.
  - Store in range: for each lane i with wmask[i]=1, mem[index] lane i <= wdata lane i; rsp_rdata <= 0, rsp_err <= 0. A mask of all zeros is legal and writes nothing.
  - Out of range: no array write, rsp_rdata <= 0, rsp_err <= 1.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready.
  - On rsp_valid && rsp_ready: if a new request is accepted in the same cycle, take the accept path with no bubble; otherwise go to IDLE and clear rsp_valid, rsp_rdata and rsp_err to 0.
- Read-after-write: a load accepted after a store's response sees the stored data, because the store commits before its rsp_valid.
- Inputs are sampled only at accept; request changes while BUSY or RESP are ignored.
- Reset mid-operation: the outstanding transaction is discarded. A store that has not yet reached RESP is not committed.
- Subtraction and comparison on addr are unsigned, ADDR_WIDTH wide; wrap-around below BASE_ADDR is caught by the addr >= BASE_ADDR check.

Test Plan:
- LATENCY=2: store addr 0x8000_0010, wdata 0xDEADBEEF, wmask 4'hF; then load the same address -> store response rsp_err=0, rsp_rdata=0 at 2 cycles after accept; load response rsp_rdata=0xDEADBEEF.
- Partial write: store 0x0000_00AA to 0x8000_0010 with wmask 4'h1 over 0xDEADBEEF, then load -> 0xDEADBEAA; load from 0x8000_0013 -> the same word.
- Out of range: load at 0x7FFF_FFFC and at BASE+4*1024 -> rsp_err=1, rsp_rdata=0; a store to BASE+4*1024 leaves mem[0] unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0. Then rsp_ready=1 with req_valid=1 -> new request accepted on the same edge, next response 2 cycles later.
- LATENCY=1 with continuous req_valid and rsp_ready -> one response every cycle, in order, correct data.
- Reset while BUSY with a pending store to 0x8000_0020 -> rsp_valid=0 after reset; a later load of 0x8000_0020 returns the old contents.
